keypad_timer_loader: RTL and testbench

- Consumes the debounced key strobe and BCD digit from the keypad encoder and builds the cook time as four BCD digits (MM:SS).
- Normalises the entered time on start and counts it down on a 1 Hz enable.
- Drives the magnetron enable and the done indication.
- Sits between the keypad encoder/debouncer stage and the display and control logic.

---
 rtl/keypad_timer_loader_if.sv | 26 ++
 rtl/keypad_timer_loader.sv | 167 ++++++++++++++++
 tb/tb_keypad_timer_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_timer_loader_if.sv
// Keypad-to-timer bus: key/control strobes toward the loader, BCD time and
// status flags back toward the display and control logic.
interface keypad_timer_loader_if;
    logic [3:0] digit;
    logic       digit_valid;
    logic       start;
    logic       stop;
    logic       clear_time;
    logic       tick_1hz;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       mag_on;
    logic       done;

    modport master (
        output digit, digit_valid, start, stop, clear_time, tick_1hz,
        input  min_tens, min_ones, sec_tens, sec_ones, mag_on, done
    );

    modport slave (
        input  digit, digit_valid, start, stop, clear_time, tick_1hz,
        output min_tens, min_ones, sec_tens, sec_ones, mag_on, done
    );
endinterface

// File: rtl/keypad_timer_loader.sv
// Builds an MM:SS cook time from keypad digits, normalises it on start and
// counts it down on a 1 Hz enable, driving magnetron enable and done.
module keypad_timer_loader #(
    parameter int MAX_DIGITS = 4
) (
    input logic                  clk,
    input logic                  rst,
    keypad_timer_loader_if.slave bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {IDLE, ENTRY, RUN, PAUSE, DONE} state_t;

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
    } bcd_time_t;

    state_t    state, next_state;
    bcd_time_t tm, tm_next;
    logic [CW-1:0] count, count_next;
    logic      digit_valid_q;
    logic      mag_on_q, done_q;
    logic      mag_on_d, done_d;
    logic      press_ok;
    logic      time_zero;

    // Seconds tens >= 6 is exactly "seconds > 59"; minutes 99 clamps instead.
    function automatic bcd_time_t normalise(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.st >= 4'd6) begin
            if (t.mt == 4'd9 && t.mo == 4'd9) begin
                r = {4'd9, 4'd9, 4'd5, 4'd9};
            end else begin
                r.st = t.st - 4'd6;
                if (t.mo == 4'd9) begin
                    r.mo = 4'd0;
                    r.mt = t.mt + 4'd1;
                end else begin
                    r.mo = t.mo + 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic bcd_time_t decrement(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.so != 4'd0) begin
            r.so = t.so - 4'd1;
        end else begin
            r.so = 4'd9;
            if (t.st != 4'd0) begin
                r.st = t.st - 4'd1;
            end else begin
                r.st = 4'd5;
                if (t.mo != 4'd0) begin
                    r.mo = t.mo - 4'd1;
                end else begin
                    r.mo = 4'd9;
                    r.mt = t.mt - 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign press_ok = bus.digit_valid && !digit_valid_q && (bus.digit <= 4'd9) &&
                      (state == IDLE || state == ENTRY || state == DONE) &&
                      (count < CW'(MAX_DIGITS));
    assign time_zero = (tm == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            tm            <= '0;
            count         <= '0;
            digit_valid_q <= 1'b0;
            mag_on_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state         <= next_state;
            tm            <= tm_next;
            count         <= count_next;
            digit_valid_q <= bus.digit_valid;
            mag_on_q      <= mag_on_d;
            done_q        <= done_d;
        end
    end

    // Each state tests only the events it reacts to, highest priority first.
    always_comb begin
        // NOTE: defaults on every path keep this block free of inferred latches.
        next_state = state;
        tm_next    = tm;
        count_next = count;
        if (bus.clear_time) begin
            next_state = IDLE;
            tm_next    = '0;
            count_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press_ok) begin
                        tm_next    = {tm.mo, tm.st, tm.so, bus.digit};
                        count_next = count + 1'b1;
                        next_state = ENTRY;
                    end
                end
                ENTRY: begin
                    if (bus.start && !time_zero) begin
                        tm_next    = normalise(tm);
                        count_next = '0;
                        next_state = RUN;
                    end else if (press_ok) begin
                        tm_next    = {tm.mo, tm.st, tm.so, bus.digit};
                        count_next = count + 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        next_state = PAUSE;
                    end else if (bus.tick_1hz) begin
                        tm_next = decrement(tm);
                        if (tm_next == '0) next_state = DONE;
                    end
                end
                PAUSE: begin
                    if (bus.stop) begin
                        next_state = IDLE;
                        tm_next    = '0;
                        count_next = '0;
                    end else if (bus.start) begin
                        next_state = RUN;
                    end
                end
                DONE: begin
                    if (bus.stop) begin
                        next_state = IDLE;
                    end else if (press_ok) begin
                        tm_next    = {12'h000, bus.digit};
                        count_next = CW'(1);
                        next_state = ENTRY;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        mag_on_d = (next_state == RUN);
        done_d   = (next_state == DONE);
    end

    assign bus.min_tens = tm.mt;
    assign bus.min_ones = tm.mo;
    assign bus.sec_tens = tm.st;
    assign bus.sec_ones = tm.so;
    assign bus.mag_on   = mag_on_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_keypad_timer_loader.sv
// Directed bench for keypad_timer_loader: a seconds-based reference model is
// compared every cycle, and literal expectations pin key points of the flow.
module tb_keypad_timer_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;
    bit   cmp_en   = 1'b0;

    keypad_timer_loader_if bus ();

    keypad_timer_loader #(.MAX_DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_ENTRY, M_RUN, M_PAUSE, M_DONE} mode_t;

    // Entry is kept as a decimal number MMSS; running time as total seconds.
    typedef struct {
        mode_t mode;
        int    entry;
        int    keys;
        int    secs;
        logic  dv_q;
    } model_t;

    model_t m;

    function automatic model_t model_step(model_t cur, logic [3:0] d, logic dv,
                                          logic st, logic sp, logic cl, logic tk);
        model_t n;
        bit     press;
        int     total;
        n      = cur;
        n.dv_q = dv;
        press  = dv && !cur.dv_q && (int'(d) <= 9) && (cur.keys < 4) &&
                 (cur.mode == M_IDLE || cur.mode == M_ENTRY || cur.mode == M_DONE);
        if (cl) begin
            n.mode = M_IDLE; n.entry = 0; n.keys = 0; n.secs = 0;
        end else begin
            case (cur.mode)
                M_IDLE: if (press) begin
                    n.entry = (cur.entry * 10 + int'(d)) % 10000;
                    n.keys  = cur.keys + 1;
                    n.mode  = M_ENTRY;
                end
                M_ENTRY: if (st && cur.entry != 0) begin
                    total  = (cur.entry / 100) * 60 + cur.entry % 100;
                    n.secs = (total > 5999) ? 5999 : total;
                    n.keys = 0;
                    n.mode = M_RUN;
                end else if (press) begin
                    n.entry = (cur.entry * 10 + int'(d)) % 10000;
                    n.keys  = cur.keys + 1;
                end
                M_RUN: if (sp) begin
                    n.mode = M_PAUSE;
                end else if (tk) begin
                    n.secs = cur.secs - 1;
                    if (n.secs == 0) n.mode = M_DONE;
                end
                M_PAUSE: if (sp) begin
                    n.mode = M_IDLE; n.entry = 0; n.keys = 0; n.secs = 0;
                end else if (st) begin
                    n.mode = M_RUN;
                end
                M_DONE: if (sp) begin
                    n.mode = M_IDLE; n.entry = 0; n.secs = 0;
                end else if (press) begin
                    n.entry = int'(d); n.keys = 1; n.secs = 0;
                    n.mode  = M_ENTRY;
                end
                default: n.mode = M_IDLE;
            endcase
        end
        return n;
    endfunction

    function automatic logic [15:0] exp_bcd(model_t mm);
        int v;
        if (mm.mode == M_IDLE || mm.mode == M_ENTRY) v = mm.entry;
        else v = (mm.secs / 60) * 100 + mm.secs % 60;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{mode: M_IDLE, entry: 0, keys: 0, secs: 0, dv_q: 1'b0};
        else     m <= model_step(m, bus.digit, bus.digit_valid, bus.start,
                                 bus.stop, bus.clear_time, bus.tick_1hz);
    end

    logic [15:0] dut_disp;
    assign dut_disp = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_disp", 32'(dut_disp), 32'(exp_bcd(m)));
            check("model_mag_on", 32'(bus.mag_on), 32'(m.mode == M_RUN));
            check("model_done", 32'(bus.done), 32'(m.mode == M_DONE));
        end
    end

    task automatic expect_disp(input string name, input logic [15:0] v);
        check(name, 32'(dut_disp), 32'(v));
        check({name, "_ref"}, 32'(exp_bcd(m)), 32'(v));
    endtask

    task automatic expect_flags(input string name, input logic mag, input logic dn);
        check({name, "_mag_on"}, 32'(bus.mag_on), 32'(mag));
        check({name, "_done"}, 32'(bus.done), 32'(dn));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_press(input logic [3:0] d, input int cycles);
        bus.digit       = d;
        bus.digit_valid = 1'b1;
        repeat (cycles) @(negedge clk);
        bus.digit_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d);
        hold_press(d, 2);
    endtask

    task automatic pulse(input bit s, input bit p, input bit c, input bit t);
        bus.start = s; bus.stop = p; bus.clear_time = c; bus.tick_1hz = t;
        @(negedge clk);
        bus.start = 0; bus.stop = 0; bus.clear_time = 0; bus.tick_1hz = 0;
    endtask

    task automatic do_start; pulse(1, 0, 0, 0); endtask
    task automatic do_stop;  pulse(0, 1, 0, 0); endtask
    task automatic do_clear; pulse(0, 0, 1, 0); endtask
    task automatic do_tick;  pulse(0, 0, 0, 1); endtask

    initial begin
        bus.digit = 4'd0; bus.digit_valid = 1'b0; bus.start = 1'b0;
        bus.stop = 1'b0; bus.clear_time = 1'b0; bus.tick_1hz = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        expect_disp("reset_disp", 16'h0000);
        expect_flags("reset", 1'b0, 1'b0);
        rst = 1'b0;
        idle(2);

        press(4'd1); press(4'd3); press(4'd0);
        expect_disp("entry_0130", 16'h0130);
        expect_flags("entry", 1'b0, 1'b0);
        do_start;
        expect_disp("start_0130", 16'h0130);
        expect_flags("start", 1'b1, 1'b0);
        do_start;
        expect_disp("start_in_run_ignored", 16'h0130);

        do_clear;
        press(4'd9); press(4'd9); press(4'd9); press(4'd9);
        do_start;
        expect_disp("clamp_9959", 16'h9959);
        do_clear;
        press(4'd1); press(4'd9); press(4'd5);
        expect_disp("entry_0195", 16'h0195);
        do_start;
        expect_disp("norm_0235", 16'h0235);

        do_clear;
        press(4'd2);
        do_start;
        do_tick;
        expect_disp("tick_0001", 16'h0001);
        expect_flags("tick1", 1'b1, 1'b0);
        do_tick;
        expect_disp("tick_0000", 16'h0000);
        expect_flags("finished", 1'b0, 1'b1);
        do_tick; do_tick;
        expect_disp("extra_ticks", 16'h0000);
        expect_flags("extra_ticks", 1'b0, 1'b1);
        press(4'd4);
        expect_disp("done_press_0004", 16'h0004);
        expect_flags("done_press", 1'b0, 1'b0);
        do_start;
        expect_flags("restart", 1'b1, 1'b0);
        do_clear;
        expect_flags("clear_run", 1'b0, 1'b0);

        press(4'd1); press(4'd0); press(4'd0); press(4'd0);
        do_start;
        do_tick;
        expect_disp("borrow_0959", 16'h0959);
        do_stop;
        do_tick; do_tick;
        expect_disp("pause_hold", 16'h0959);
        expect_flags("pause", 1'b0, 1'b0);
        do_start;
        do_tick;
        expect_disp("resume_0958", 16'h0958);
        pulse(0, 1, 0, 1);
        expect_disp("stop_beats_tick", 16'h0958);
        expect_flags("stop_beats_tick", 1'b0, 1'b0);
        do_stop;
        expect_disp("pause_stop_clear", 16'h0000);

        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        expect_disp("fifth_ignored", 16'h1234);
        do_clear;
        press(4'd12);
        expect_disp("code12_ignored", 16'h0000);
        hold_press(4'd7, 5);
        expect_disp("held_one_press", 16'h0007);
        pulse(1, 0, 1, 0);
        expect_disp("clear_beats_start", 16'h0000);
        expect_flags("clear_beats_start", 1'b0, 1'b0);
        do_start;
        expect_flags("start_zero_ignored", 1'b0, 1'b0);

        press(4'd5); press(4'd0); press(4'd0);
        do_start;
        idle(3);
        #2 rst = 1'b1;
        #1;
        expect_disp("async_rst_disp", 16'h0000);
        expect_flags("async_rst", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        do_tick;
        idle(1);
        expect_disp("post_rst_tick", 16'h0000);
        expect_flags("post_rst_tick", 1'b0, 1'b0);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
